// File: rtl/prog_clock_divider.sv
// prog_clock_divider: programmable clock divider with ready/valid ratio update applied on period boundaries
module prog_clock_divider #(
  parameter int WIDTH = 8,
  parameter int RESET_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_div_valid,
  input  logic [WIDTH-1:0] io_div_bits,
  output logic             io_div_ready,
  output logic             io_clock_out,
  output logic             io_tick,
  output logic             io_active
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] one = WIDTH'(1);
  localparam logic [WIDTH-1:0] two = WIDTH'(2);
  state_t state, state_nx;
  logic [WIDTH-1:0] n, n_nx, cnt, cnt_nx, pend, pend_nx, sat;
  logic [WIDTH:0] half, cnt_inc;
  logic pend_vld, pend_vld_nx, out_nx, tick_nx, xfer, boundary;
  assign io_div_ready = !pend_vld;
  assign io_active = state == RUN;
  assign xfer = io_div_valid && !pend_vld;
  assign sat = io_div_bits < two ? two : io_div_bits;
  // high phase length is computed one bit wider so N = 2^WIDTH-1 cannot wrap
  assign half = ({1'b0, n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign cnt_inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign boundary = state == RUN && cnt == n - one;
  always_comb begin
    state_nx = state;
    n_nx = n;
    cnt_nx = cnt;
    pend_nx = pend;
    pend_vld_nx = pend_vld;
    out_nx = 1'b0;
    tick_nx = 1'b0;
    if (state == IDLE) begin
      n_nx = xfer ? sat : n;
      cnt_nx = '0;
      state_nx = io_en ? RUN : IDLE;
      out_nx = io_en;
      tick_nx = io_en;
    end else if (boundary) begin
      n_nx = pend_vld ? pend : xfer ? sat : n;
      pend_vld_nx = 1'b0;
      cnt_nx = '0;
      state_nx = io_en ? RUN : IDLE;
      out_nx = io_en;
      tick_nx = io_en;
    end else begin
      cnt_nx = cnt_inc[WIDTH-1:0];
      out_nx = cnt_inc < half;
      pend_nx = xfer ? sat : pend;
      pend_vld_nx = pend_vld || xfer;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      n <= WIDTH'(RESET_DIV);
      cnt <= '0;
      pend <= '0;
      pend_vld <= 1'b0;
      io_clock_out <= 1'b0;
      io_tick <= 1'b0;
    end else begin
      state <= state_nx;
      n <= n_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      pend_vld <= pend_vld_nx;
      io_clock_out <= out_nx;
      io_tick <= tick_nx;
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: random stimulus against a period-position reference model
module tb_prog_clock_divider;
  localparam int WIDTH = 8;
  localparam int RESET_DIV = 4;
  logic clock = 1'b0, reset = 1'b1, io_en = 1'b0, io_div_valid = 1'b0;
  logic [WIDTH-1:0] io_div_bits = '0;
  logic io_div_ready, io_clock_out, io_tick, io_active;
  int total = 0, bad = 0;
  bit running = 0;
  int n = RESET_DIV, pos = 0;
  int pend_q[$];
  prog_clock_divider #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clock(clock), .reset(reset), .io_en(io_en), .io_div_valid(io_div_valid),
    .io_div_bits(io_div_bits), .io_div_ready(io_div_ready), .io_clock_out(io_clock_out),
    .io_tick(io_tick), .io_active(io_active)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", tag, $time, got, exp);
    end
  endtask
  function automatic int sat(input int b);
    return b < 2 ? 2 : b;
  endfunction
  // one clock edge of the specified behaviour, in terms of position within the period
  task automatic model_step();
    bit xfer = io_div_valid && pend_q.size() == 0;
    if (reset) begin
      running = 0; pos = 0; n = RESET_DIV; pend_q.delete();
    end else if (!running) begin
      if (xfer) n = sat(int'(io_div_bits));
      if (io_en) begin running = 1; pos = 0; end
    end else if (pos == n - 1) begin
      if (pend_q.size() != 0) n = pend_q.pop_front();
      else if (xfer) n = sat(int'(io_div_bits));
      pos = 0;
      running = io_en;
    end else begin
      pos++;
      if (xfer) pend_q.push_back(sat(int'(io_div_bits)));
    end
  endtask
  task automatic check_all();
    check("clock_out", int'(io_clock_out), int'(running && pos < (n + 1) / 2));
    check("tick", int'(io_tick), int'(running && pos == 0));
    check("active", int'(io_active), int'(running));
    check("div_ready", int'(io_div_ready), int'(pend_q.size() == 0));
  endtask
  function automatic logic [WIDTH-1:0] pick_ratio();
    int k = $urandom_range(0, 5);
    return k == 0 ? 8'd0 : k == 1 ? 8'd1 : k == 2 ? 8'd255 :
           k == 3 ? WIDTH'($urandom_range(2, 9)) : WIDTH'($urandom_range(0, 255));
  endfunction
  initial begin
    @(posedge clock);
    model_step();
    #1;
    check("reset_clock_out", int'(io_clock_out), 0);
    check("reset_tick", int'(io_tick), 0);
    check("reset_active", int'(io_active), 0);
    check("reset_ready", int'(io_div_ready), 1);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      reset = i > 0 && $urandom_range(0, 399) == 0;
      io_en = i < 40 ? 1'b1 : $urandom_range(0, 11) != 0;
      io_div_valid = i >= 20 && $urandom_range(0, 9) == 0;
      io_div_bits = pick_ratio();
      @(posedge clock);
      model_step();
      #1;
      check_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
